// File: rtl/lab_seq_pkg.sv
// Shared definitions for the lab's sequential blocks: FSM state encoding and
// the bit-counter width helper.
package lab_seq_pkg;

    // Frame states. ST_PAR is only reachable in a parity-checking build.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_e;

    // Counter width able to hold 0..WIDTH+1 accepted bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/dff_sync.sv
// Single-bit D flip-flop cell with synchronous active-high clear and enable.
// Clear has priority over enable.
module dff_sync (
    input  logic clk,
    input  logic clr_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    // Storage bit: clear first, then load when enabled, otherwise hold.
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its neighbour; with = a shift chain would collapse.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            q_q <= 1'b0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer, MSB first. Qualified bits shift into a
// WIDTH-long chain of dff_sync cells; a completed frame is presented on pout
// with a one-cycle pout_valid pulse.
// Build option: define PARITY_CHECK_EN to append and check an even-parity bit
// after the data bits of every frame.
module sipo_deser
    import lab_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    output logic             parity_err,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt
);

    state_e           state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic [WIDTH-1:0] pout_q;
    logic             pout_valid_q;
    logic             parity_err_q;

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_d;
    logic             accept;
    logic             shift_en;
    logic             complete;
    logic             cell_clr;
    logic             parity_err_d;

    // Qualify the incoming bit and decide whether this edge shifts, completes
    // a frame, or both.
    // NOTE: every signal gets a value on every path through always_comb, so
    // no latch can be inferred.
    always_comb begin
        accept    = sin_valid & ~flush;
        bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef PARITY_CHECK_EN
        // Data is complete in shreg; the bit arriving in ST_PAR is parity.
        complete     = accept & (state_q == ST_PAR);
        shift_en     = accept & (state_q != ST_PAR);
        word_d       = shreg;
        parity_err_d = (^shreg) ^ sin;
`else
        // The last data bit goes straight to pout, bypassing the chain.
        complete     = accept & (bit_cnt_q == CNT_W'(WIDTH - 1));
        shift_en     = accept;
        word_d       = {shreg[WIDTH-2:0], sin};
        parity_err_d = 1'b0;
`endif
        cell_clr = clr | flush | complete;
    end

`ifndef PARITY_CHECK_EN
    // The oldest bit shifts out of the word on completion and is never read.
    logic unused_msb;
    assign unused_msb = shreg[WIDTH-1];
`endif

    // Shift register built as a literal chain of D cells, cell 0 takes sin.
    // NOTE: the chain is cleared through the cells' synchronous clear on
    // reset, flush and completion, so a new frame always starts from zero.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == 0) begin : g_head
            dff_sync u_cell (
                .clk   (clk),
                .clr_i (cell_clr),
                .en_i  (shift_en),
                .d_i   (sin),
                .q_o   (shreg[0])
            );
        end else begin : g_body
            dff_sync u_cell (
                .clk   (clk),
                .clr_i (cell_clr),
                .en_i  (shift_en),
                .d_i   (shreg[i-1]),
                .q_o   (shreg[i])
            );
        end
    end

    // Frame FSM with bit counter and registered outputs; clr beats flush,
    // flush beats an incoming bit.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            pout_valid_q <= 1'b0;
            if (flush) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
            end else if (complete) begin
                state_q      <= ST_IDLE;
                bit_cnt_q    <= '0;
                pout_q       <= word_d;
                pout_valid_q <= 1'b1;
                parity_err_q <= parity_err_d;
            end else if (accept) begin
                bit_cnt_q <= bit_cnt_d;
                state_q   <= (bit_cnt_d == CNT_W'(WIDTH)) ? ST_PAR : ST_SHIFT;
            end
        end
    end

    assign pout       = pout_q;
    assign pout_valid = pout_valid_q;
    assign parity_err = parity_err_q;
    assign busy       = (state_q != ST_IDLE);
    assign bit_cnt    = bit_cnt_q;

endmodule
